core_completion_ctrl: RTL and testbench
=======================================

CORE_COMPLETION_CTRL -- requirements
Module: core_completion_ctrl

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: number of processor cores supervised, 1..16.
REQ-002 SHALL have parameter CNT_W, default 32: width of the run-cycle counter and timeout limit.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: single-cycle request to begin a run.
REQ-006 SHALL have port core_status, input, NUM_CORES: per-core enable mask, sampled on an accepted start.
REQ-007 SHALL have port end_process, input, NUM_CORES: per-core completion indication, level or pulse.
REQ-008 SHALL have port timeout_limit, input, CNT_W: run-cycle limit, sampled on an accepted start; 0 disables the timeout.
REQ-009 SHALL have port core_run, output, NUM_CORES: per-core run enable.
REQ-010 SHALL have port done_mask, output, NUM_CORES: sticky per-core completion flags.
REQ-011 SHALL have port busy, output, 1: high while in RUN.
REQ-012 SHALL have port terminate, output, 1: all enabled cores complete.
REQ-013 SHALL have port timeout, output, 1: run aborted by the limit.
REQ-014 SHALL have port cycle_count, output, CNT_W: cycles spent in RUN.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE and TOUT.
REQ-016 SHALL accept start only in IDLE, DONE or TOUT, and only when core_status is nonzero; a start with core_status == 0 is ignored and the state is unchanged.
REQ-017 On an accepted start, SHALL on the next edge: latch active_mask = core_status and limit = timeout_limit; clear done_mask, cycle_count, terminate and timeout; enter RUN.
REQ-018 SHALL ignore start while in RUN.
REQ-019 SHALL ignore changes to core_status or timeout_limit while in RUN.
REQ-020 SHALL allow any active_mask pattern; contiguous masks are not required.
REQ-021 In RUN, SHALL drive core_run = active_mask; in every other state core_run = 0.
REQ-022 In RUN, each edge SHALL set done_mask |= end_process & active_mask; bits outside active_mask never set.
REQ-023 In RUN, cycle_count SHALL increment by 1 per edge, saturating at 2^CNT_W-1 with no wrap.
REQ-024 Let next_done = done_mask | (end_process & active_mask). When next_done == active_mask, the FSM SHALL enter DONE and set terminate to 1 on that same edge (one-cycle latency from the sampled end_process).
REQ-025 Otherwise, when limit != 0 and cycle_count + 1 == limit, the FSM SHALL enter TOUT and set timeout to 1 on that same edge.
REQ-026 If completion and timeout occur on the same edge, completion SHALL win: enter DONE with terminate = 1 and timeout = 0.
REQ-027 In DONE and TOUT, all outputs SHALL hold until an accepted start or rst.
REQ-028 terminate and timeout SHALL never be 1 simultaneously.
REQ-029 busy SHALL equal (state == RUN).

Reset
REQ-030 On rst high at an edge, SHALL enter IDLE and clear terminate, timeout, busy, core_run, done_mask, cycle_count, active_mask and limit to 0.
REQ-031 rst SHALL take priority over start and end_process on the same edge, including mid-RUN.

Structure
REQ-032 SHALL take its FSM state enum and the NUM_CORES and CNT_W defaults from the shared package core_ctrl_pkg.
REQ-033 SHALL implement the counter as one sub-module, sat_counter: clear, enable, saturating, CNT_W wide.
REQ-034 All outputs SHALL be registered, except busy and core_run, which are decoded from registered state only.

Verification
REQ-035 Bench SHALL cover: NUM_CORES = 4; start with core_status = 4'b1111, limit 0; end_process bits pulsed at cycles 3, 5, 7 and 9 -> terminate = 1 one cycle after the cycle-9 sample; done_mask = 4'hF; cycle_count = 10.
REQ-036 Bench SHALL cover: start with core_status = 4'b1010; end_process = 4'b0101 held, then 4'b1010 at cycle 4 -> done_mask stays 0 until cycle 4, then reaches 4'b1010; terminate follows one cycle later.
REQ-037 Bench SHALL cover: start with core_status = 4'b0011, limit = 5; only bit 0 completes -> timeout = 1, terminate = 0, cycle_count = 5, core_run = 0.
REQ-038 Bench SHALL cover: limit = 5; last enabled core completes on the edge where cycle_count + 1 == 5 -> DONE with terminate = 1 and timeout = 0.
REQ-039 Bench SHALL cover: start with core_status = 0 -> stays IDLE, busy = 0; start mid-RUN -> ignored; rst at cycle 3 of RUN -> all outputs 0 on the next cycle.
REQ-040 Bench SHALL cover: CNT_W = 4, limit 0, no completion for 20 cycles -> cycle_count saturates at 15; then a fresh start from DONE clears the flags and re-enters RUN.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared FSM state encoding and parameter defaults for the core completion controller.
package core_ctrl_pkg;

  localparam int NUM_CORES_DEF = 4;
  localparam int CNT_W_DEF     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_TOUT = 2'd3
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clear wins over enable, holds at all-ones; result visible one edge later.
// No backpressure; the count simply stops at its maximum value.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/core_completion_ctrl.sv
// Supervises a run of NUM_CORES cores: done/timeout flags register one edge after the sampled cause.
// No backpressure: start is a one-cycle request, dropped unless the FSM is out of RUN and the mask is nonzero.
module core_completion_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] core_status,
  input  logic [NUM_CORES-1:0] end_process,
  input  logic [CNT_W-1:0]     timeout_limit,
  output logic [NUM_CORES-1:0] core_run,
  output logic [NUM_CORES-1:0] done_mask,
  output logic                 busy,
  output logic                 terminate,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycle_count
);

  localparam logic [CNT_W:0] ONE_EXT = {{CNT_W{1'b0}}, 1'b1};

  state_t                 state, state_nxt;
  logic [NUM_CORES-1:0]   active_mask;
  logic [CNT_W-1:0]       limit;
  logic [NUM_CORES-1:0]   done_nxt;
  logic [NUM_CORES-1:0]   run_done;
  logic                   term_nxt;
  logic                   tout_nxt;
  logic                   load;
  logic                   start_ok;
  logic                   all_done;
  logic                   hit_limit;

  assign start_ok = start && (|core_status) && (state != ST_RUN);
  assign run_done = done_mask | (end_process & active_mask);
  assign all_done = (run_done == active_mask);
  // Extended compare so a saturated count can never alias back onto a small limit.
  assign hit_limit = (limit != '0) &&
                     (({1'b0, cycle_count} + ONE_EXT) == {1'b0, limit});

  always_comb begin
    state_nxt = state;
    done_nxt  = done_mask;
    term_nxt  = terminate;
    tout_nxt  = timeout;
    load      = 1'b0;
    case (state)
      ST_RUN: begin
        done_nxt = run_done;
        if (all_done) begin
          state_nxt = ST_DONE;
          term_nxt  = 1'b1;
        end else if (hit_limit) begin
          state_nxt = ST_TOUT;
          tout_nxt  = 1'b1;
        end
      end
      default: begin
        if (start_ok) begin
          state_nxt = ST_RUN;
          done_nxt  = '0;
          term_nxt  = 1'b0;
          tout_nxt  = 1'b0;
          load      = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      active_mask <= '0;
      limit       <= '0;
      done_mask   <= '0;
      terminate   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state     <= state_nxt;
      done_mask <= done_nxt;
      terminate <= term_nxt;
      timeout   <= tout_nxt;
      if (load) begin
        active_mask <= core_status;
        limit       <= timeout_limit;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (load),
    .en    (state == ST_RUN),
    .count (cycle_count)
  );

  assign busy     = (state == ST_RUN);
  assign core_run = (state == ST_RUN) ? active_mask : '0;

  a_flags_exclusive : assert property (@(posedge clk) !(terminate && timeout));

endmodule

// File: tb/tb_core_completion_ctrl.sv
// Directed vector bench for core_completion_ctrl, plus a narrow-counter instance for saturation.
module tb_core_completion_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  core_status;
  logic [3:0]  end_process;
  logic [31:0] timeout_limit;
  logic [3:0]  timeout_limit4;

  logic [3:0]  core_run,  core_run4;
  logic [3:0]  done_mask, done_mask4;
  logic        busy, busy4, terminate, terminate4, timeout, timeout4;
  logic [31:0] cycle_count;
  logic [3:0]  cycle_count4;

  int n_vec = 0;
  int n_err = 0;

  assign timeout_limit4 = timeout_limit[3:0];

  core_completion_ctrl #(.NUM_CORES(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .core_status(core_status),
    .end_process(end_process), .timeout_limit(timeout_limit),
    .core_run(core_run), .done_mask(done_mask), .busy(busy),
    .terminate(terminate), .timeout(timeout), .cycle_count(cycle_count)
  );

  core_completion_ctrl #(.NUM_CORES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .core_status(core_status),
    .end_process(end_process), .timeout_limit(timeout_limit4),
    .core_run(core_run4), .done_mask(done_mask4), .busy(busy4),
    .terminate(terminate4), .timeout(timeout4), .cycle_count(cycle_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic [3:0]  status;
    logic [3:0]  endp;
    logic [31:0] limit;
    logic        e_busy;
    logic [3:0]  e_run;
    logic [3:0]  e_done;
    logic        e_term;
    logic        e_tout;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t  vecs[$];
  string names[$];

  task automatic add(input string nm, input logic r, input logic s,
                     input logic [3:0] st, input logic [3:0] ep, input logic [31:0] lim,
                     input logic eb, input logic [3:0] er, input logic [3:0] ed,
                     input logic et, input logic eto, input logic [31:0] ec);
    vec_t v;
    v.rst = r; v.start = s; v.status = st; v.endp = ep; v.limit = lim;
    v.e_busy = eb; v.e_run = er; v.e_done = ed; v.e_term = et; v.e_tout = eto; v.e_cnt = ec;
    vecs.push_back(v);
    names.push_back(nm);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; core_status = '0; end_process = '0; timeout_limit = '0;

    //         name        rst st  stat  endp  lim     busy run   done  term tout cnt
    add("reset0",    1, 0, 4'h0, 4'h0, 0,      0, 4'h0, 4'h0, 0, 0, 0);
    add("reset_pri", 1, 1, 4'hF, 4'hF, 7,      0, 4'h0, 4'h0, 0, 0, 0);
    // all four cores, completions staggered; status/limit changes mid-run must not matter
    add("b_start",   0, 1, 4'hF, 4'h0, 0,      1, 4'hF, 4'h0, 0, 0, 0);
    add("b_c0",      0, 0, 4'h3, 4'h0, 9,      1, 4'hF, 4'h0, 0, 0, 1);
    add("b_c1",      0, 0, 4'h3, 4'h0, 9,      1, 4'hF, 4'h0, 0, 0, 2);
    add("b_c2",      0, 0, 4'h3, 4'h0, 9,      1, 4'hF, 4'h0, 0, 0, 3);
    add("b_c3",      0, 0, 4'h3, 4'h1, 9,      1, 4'hF, 4'h1, 0, 0, 4);
    add("b_c4",      0, 0, 4'h3, 4'h0, 9,      1, 4'hF, 4'h1, 0, 0, 5);
    add("b_c5",      0, 0, 4'h3, 4'h2, 9,      1, 4'hF, 4'h3, 0, 0, 6);
    add("b_c6",      0, 0, 4'h3, 4'h0, 9,      1, 4'hF, 4'h3, 0, 0, 7);
    add("b_c7",      0, 0, 4'h3, 4'h4, 9,      1, 4'hF, 4'h7, 0, 0, 8);
    add("b_c8",      0, 0, 4'h3, 4'h0, 9,      1, 4'hF, 4'h7, 0, 0, 9);
    add("b_c9",      0, 0, 4'h3, 4'h8, 9,      0, 4'h0, 4'hF, 1, 0, 10);
    add("b_hold",    0, 0, 4'h0, 4'hF, 0,      0, 4'h0, 4'hF, 1, 0, 10);
    // non-contiguous mask; wrong cores report first
    add("c_start",   0, 1, 4'hA, 4'h5, 0,      1, 4'hA, 4'h0, 0, 0, 0);
    add("c_c0",      0, 0, 4'hF, 4'h5, 0,      1, 4'hA, 4'h0, 0, 0, 1);
    add("c_c1",      0, 0, 4'hF, 4'h5, 0,      1, 4'hA, 4'h0, 0, 0, 2);
    add("c_c2",      0, 0, 4'hF, 4'h5, 0,      1, 4'hA, 4'h0, 0, 0, 3);
    add("c_c3",      0, 0, 4'hF, 4'h5, 0,      1, 4'hA, 4'h0, 0, 0, 4);
    add("c_c4",      0, 0, 4'hF, 4'hA, 0,      0, 4'h0, 4'hA, 1, 0, 5);
    // timeout with limit 5; live limit input moved to 2 to show it is latched
    add("d_start",   0, 1, 4'h3, 4'h0, 5,      1, 4'h3, 4'h0, 0, 0, 0);
    add("d_c0",      0, 0, 4'hF, 4'h1, 2,      1, 4'h3, 4'h1, 0, 0, 1);
    add("d_c1",      0, 0, 4'hF, 4'h0, 2,      1, 4'h3, 4'h1, 0, 0, 2);
    add("d_c2",      0, 0, 4'hF, 4'h0, 2,      1, 4'h3, 4'h1, 0, 0, 3);
    add("d_c3",      0, 0, 4'hF, 4'h0, 2,      1, 4'h3, 4'h1, 0, 0, 4);
    add("d_c4",      0, 0, 4'hF, 4'h0, 2,      0, 4'h0, 4'h1, 0, 1, 5);
    add("d_hold",    0, 0, 4'hF, 4'h2, 2,      0, 4'h0, 4'h1, 0, 1, 5);
    // completion on the same edge as the limit: completion wins
    add("e_start",   0, 1, 4'h3, 4'h0, 5,      1, 4'h3, 4'h0, 0, 0, 0);
    add("e_c0",      0, 0, 4'h3, 4'h1, 5,      1, 4'h3, 4'h1, 0, 0, 1);
    add("e_c1",      0, 0, 4'h3, 4'h0, 5,      1, 4'h3, 4'h1, 0, 0, 2);
    add("e_c2",      0, 0, 4'h3, 4'h0, 5,      1, 4'h3, 4'h1, 0, 0, 3);
    add("e_c3",      0, 0, 4'h3, 4'h0, 5,      1, 4'h3, 4'h1, 0, 0, 4);
    add("e_c4",      0, 0, 4'h3, 4'h2, 5,      0, 4'h0, 4'h3, 1, 0, 5);
    // empty start, start mid-run, reset mid-run
    add("f_rst",     1, 0, 4'h0, 4'h0, 0,      0, 4'h0, 4'h0, 0, 0, 0);
    add("f_zero",    0, 1, 4'h0, 4'h0, 0,      0, 4'h0, 4'h0, 0, 0, 0);
    add("f_start",   0, 1, 4'h4, 4'h0, 0,      1, 4'h4, 4'h0, 0, 0, 0);
    add("f_c0",      0, 0, 4'h4, 4'h0, 0,      1, 4'h4, 4'h0, 0, 0, 1);
    add("f_mid",     0, 1, 4'hF, 4'h0, 2,      1, 4'h4, 4'h0, 0, 0, 2);
    add("f_c2",      0, 0, 4'h4, 4'h0, 0,      1, 4'h4, 4'h0, 0, 0, 3);
    add("f_rstrun",  1, 1, 4'hF, 4'h4, 0,      0, 4'h0, 4'h0, 0, 0, 0);
    add("f_idle",    0, 0, 4'h0, 4'h0, 0,      0, 4'h0, 4'h0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst           = vecs[i].rst;
      start         = vecs[i].start;
      core_status   = vecs[i].status;
      end_process   = vecs[i].endp;
      timeout_limit = vecs[i].limit;
      step();
      chk(names[i],
          {18'd0, busy, core_run, done_mask, terminate, timeout, cycle_count},
          {18'd0, vecs[i].e_busy, vecs[i].e_run, vecs[i].e_done,
           vecs[i].e_term, vecs[i].e_tout, vecs[i].e_cnt});
    end

    // Narrow counter saturates, then a restart from DONE clears everything
    rst = 1'b0; start = 1'b1; core_status = 4'h1; end_process = 4'h0; timeout_limit = 0;
    step();
    chk("g_start", {busy4, cycle_count4}, {1'b1, 4'd0});
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("g_sat%0d", k), {60'd0, cycle_count4}, (k > 15) ? 64'd15 : 64'(k));
    end
    end_process = 4'h1;
    step();
    chk("g_done4", {busy4, terminate4, timeout4, done_mask4, cycle_count4},
        {1'b1 ^ 1'b1, 1'b1, 1'b0, 4'h1, 4'd15});
    chk("g_done32", {32'd0, cycle_count}, 64'd21);
    end_process = 4'h0; start = 1'b1; core_status = 4'h3;
    step();
    chk("g_restart", {busy4, core_run4, done_mask4, terminate4, timeout4, cycle_count4},
        {1'b1, 4'h3, 4'h0, 1'b0, 1'b0, 4'd0});
    start = 1'b0;
    step();
    chk("g_count", {busy4, cycle_count4}, {1'b1, 4'd1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
